// File: rtl/xsim_ctl_pkg.sv
// Shared types and helpers for the simulation run controller.
package xsim_ctl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_COUNT_W = 32;

  // Bits needed to hold the values 0 .. n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xsim_run_ctrl_if.sv
// Run-control bus between the DPI cycle hook (master) and the controller (slave).
interface xsim_run_ctrl_if #(
  parameter int COUNT_W = xsim_ctl_pkg::DEF_COUNT_W
);

  logic                  finish_req;
  logic                  dut_rst_n;
  logic                  running;
  logic                  sim_done;
  logic                  timeout;
  xsim_ctl_pkg::state_t  state;
  logic [COUNT_W-1:0]    cycle_count;

  modport master (
    output finish_req,
    input  dut_rst_n, running, sim_done, timeout, state, cycle_count
  );

  modport slave (
    input  finish_req,
    output dut_rst_n, running, sim_done, timeout, state, cycle_count
  );

endinterface

// File: rtl/xsim_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module xsim_sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/xsim_run_ctrl.sv
// Simulation run controller: DUT reset release, finish request, drain, sim_done.
// Define XSIMCTL_WATCHDOG_EN to enable the TIMEOUT_CYCLES watchdog.
module xsim_run_ctrl
  import xsim_ctl_pkg::*;
#(
  parameter int RESET_CYCLES   = 20,
  parameter int DRAIN_CYCLES   = 4,
  parameter int COUNT_W        = DEF_COUNT_W,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic          CLK,
  input  logic          RST,
  xsim_run_ctrl_if.slave bus
);

  localparam int HOLD_W  = cnt_width(RESET_CYCLES);
  localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  if (RESET_CYCLES < 1 || DRAIN_CYCLES < 0 || TIMEOUT_CYCLES < 0) begin : g_param_check
    $error("xsim_run_ctrl: RESET_CYCLES must be >= 1, DRAIN/TIMEOUT_CYCLES >= 0");
  end

  state_t               state;
  logic                 dut_rst_n_q;
  logic                 running_q;
  logic                 sim_done_q;
  logic                 pend;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic [COUNT_W-1:0]   cycle_count;
  logic                 hold_last;
  logic                 drain_last;

  assign hold_last  = (hold_cnt == HOLD_LAST);
  assign drain_last = (drain_cnt == DRAIN_LAST);

  xsim_sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (1'b0),
    .enable (state == HOLD),
    .count  (hold_cnt)
  );

  // Cleared every RUN cycle so it always starts at zero on entry to DRAIN.
  xsim_sat_counter #(.W(DRAIN_W)) u_drain_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (state == RUN),
    .enable (state == DRAIN),
    .count  (drain_cnt)
  );

  xsim_sat_counter #(.W(COUNT_W)) u_cycle_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (1'b0),
    .enable ((state == RUN) || (state == DRAIN)),
    .count  (cycle_count)
  );

`ifdef XSIMCTL_WATCHDOG_EN
  logic timeout_q;
  logic wdog_hit;

  // Fire on the edge that brings cycle_count to the limit, so the count freezes exactly there.
  assign wdog_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == COUNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= HOLD;
      dut_rst_n_q <= 1'b0;
      running_q   <= 1'b0;
      sim_done_q  <= 1'b0;
      pend        <= 1'b0;
`ifdef XSIMCTL_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state)
        HOLD: begin
          if (bus.finish_req) begin
            pend <= 1'b1;
          end
          if (hold_last) begin
            // A finish seen during reset skips RUN entirely; the DUT never leaves reset.
            if (pend || bus.finish_req) begin
              if (DRAIN_CYCLES == 0) begin
                state      <= DONE;
                sim_done_q <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end else begin
              state       <= RUN;
              running_q   <= 1'b1;
              dut_rst_n_q <= 1'b1;
            end
          end
        end
        RUN: begin
`ifdef XSIMCTL_WATCHDOG_EN
          if (wdog_hit) begin
            state      <= DONE;
            running_q  <= 1'b0;
            sim_done_q <= 1'b1;
            timeout_q  <= 1'b1;
          end else
`endif
          if (bus.finish_req) begin
            running_q <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              state      <= DONE;
              sim_done_q <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_last) begin
            state      <= DONE;
            sim_done_q <= 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign bus.state       = state;
  assign bus.dut_rst_n   = dut_rst_n_q;
  assign bus.running     = running_q;
  assign bus.sim_done    = sim_done_q;
  assign bus.cycle_count = cycle_count;

endmodule

// File: tb/tb_xsim_run_ctrl.sv
// Directed bench for xsim_run_ctrl: default, zero-drain and watchdog-configured instances.
module tb_xsim_run_ctrl;
  import xsim_ctl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  xsim_run_ctrl_if #(.COUNT_W(32)) a_if ();
  xsim_run_ctrl_if #(.COUNT_W(32)) z_if ();
  xsim_run_ctrl_if #(.COUNT_W(32)) w_if ();

  xsim_run_ctrl #(.RESET_CYCLES(20), .DRAIN_CYCLES(4), .COUNT_W(32), .TIMEOUT_CYCLES(0))
    dut_a (.CLK(CLK), .RST(RST), .bus(a_if));
  xsim_run_ctrl #(.RESET_CYCLES(20), .DRAIN_CYCLES(0), .COUNT_W(32), .TIMEOUT_CYCLES(0))
    dut_z (.CLK(CLK), .RST(RST), .bus(z_if));
  xsim_run_ctrl #(.RESET_CYCLES(20), .DRAIN_CYCLES(4), .COUNT_W(32), .TIMEOUT_CYCLES(50))
    dut_w (.CLK(CLK), .RST(RST), .bus(w_if));

  // One active edge, then settle on the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    a_if.finish_req = 1'b0;
    z_if.finish_req = 1'b0;
    w_if.finish_req = 1'b0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++; if (a_if.state !== HOLD) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected %0d", a_if.state, HOLD); end
    n_checks++; if (a_if.dut_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dut_rst_n: got %b expected 0", a_if.dut_rst_n); end
    n_checks++; if (a_if.running !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_running: got %b expected 0", a_if.running); end
    n_checks++; if (a_if.sim_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sim_done: got %b expected 0", a_if.sim_done); end
    n_checks++; if (a_if.timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout: got %b expected 0", a_if.timeout); end
    n_checks++; if (a_if.cycle_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cycle_count: got %0d expected 0", a_if.cycle_count); end
    RST = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++; if (a_if.dut_rst_n !== (e == 20)) begin n_fail++; $display("[TB] FAIL release_edge%0d: got %b expected %b", e, a_if.dut_rst_n, (e == 20)); end
    end
    n_checks++; if (a_if.state !== RUN) begin n_fail++; $display("[TB] FAIL release_state: got %0d expected %0d", a_if.state, RUN); end
    n_checks++; if (a_if.running !== 1'b1) begin n_fail++; $display("[TB] FAIL release_running: got %b expected 1", a_if.running); end
    n_checks++; if (a_if.cycle_count !== 32'd0) begin n_fail++; $display("[TB] FAIL release_count: got %0d expected 0", a_if.cycle_count); end
  endtask

  task automatic test_drain_zero();
    z_if.finish_req = 1'b1;
    tick();
    z_if.finish_req = 1'b0;
    n_checks++; if (z_if.state !== DONE) begin n_fail++; $display("[TB] FAIL dz_state: got %0d expected %0d", z_if.state, DONE); end
    n_checks++; if (z_if.sim_done !== 1'b1) begin n_fail++; $display("[TB] FAIL dz_sim_done: got %b expected 1", z_if.sim_done); end
    n_checks++; if (z_if.running !== 1'b0) begin n_fail++; $display("[TB] FAIL dz_running: got %b expected 0", z_if.running); end
    n_checks++; if (z_if.cycle_count !== 32'd1) begin n_fail++; $display("[TB] FAIL dz_count: got %0d expected 1", z_if.cycle_count); end
    repeat (3) tick();
    n_checks++; if (z_if.cycle_count !== 32'd1) begin n_fail++; $display("[TB] FAIL dz_count_frozen: got %0d expected 1", z_if.cycle_count); end
  endtask

  task automatic test_finish_drain();
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (a_if.cycle_count == 32'd100) found = 1'b1;
      else tick();
    end
    n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL wait_count100: got %0d expected 100", a_if.cycle_count); end
    a_if.finish_req = 1'b1;
    tick();
    a_if.finish_req = 1'b0;
    n_checks++; if (a_if.state !== DRAIN) begin n_fail++; $display("[TB] FAIL e0_state: got %0d expected %0d", a_if.state, DRAIN); end
    n_checks++; if (a_if.cycle_count !== 32'd101) begin n_fail++; $display("[TB] FAIL e0_count: got %0d expected 101", a_if.cycle_count); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (a_if.sim_done !== 1'b0) begin n_fail++; $display("[TB] FAIL drain%0d_sim_done: got %b expected 0", k, a_if.sim_done); end
      n_checks++; if (a_if.state !== DRAIN) begin n_fail++; $display("[TB] FAIL drain%0d_state: got %0d expected %0d", k, a_if.state, DRAIN); end
    end
    tick();
    n_checks++; if (a_if.sim_done !== 1'b1) begin n_fail++; $display("[TB] FAIL done_sim_done: got %b expected 1", a_if.sim_done); end
    n_checks++; if (a_if.state !== DONE) begin n_fail++; $display("[TB] FAIL done_state: got %0d expected %0d", a_if.state, DONE); end
    n_checks++; if (a_if.cycle_count !== 32'd105) begin n_fail++; $display("[TB] FAIL done_count: got %0d expected 105", a_if.cycle_count); end
    a_if.finish_req = 1'b1;
    repeat (5) tick();
    a_if.finish_req = 1'b0;
    n_checks++; if (a_if.cycle_count !== 32'd105) begin n_fail++; $display("[TB] FAIL frozen_count: got %0d expected 105", a_if.cycle_count); end
    n_checks++; if (a_if.sim_done !== 1'b1) begin n_fail++; $display("[TB] FAIL sticky_sim_done: got %b expected 1", a_if.sim_done); end
    n_checks++; if (a_if.dut_rst_n !== 1'b1) begin n_fail++; $display("[TB] FAIL done_dut_rst_n: got %b expected 1", a_if.dut_rst_n); end
  endtask

  task automatic test_watchdog();
`ifdef XSIMCTL_WATCHDOG_EN
    n_checks++; if (w_if.state !== DONE) begin n_fail++; $display("[TB] FAIL wd_state: got %0d expected %0d", w_if.state, DONE); end
    n_checks++; if (w_if.timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_timeout: got %b expected 1", w_if.timeout); end
    n_checks++; if (w_if.sim_done !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_sim_done: got %b expected 1", w_if.sim_done); end
    n_checks++; if (w_if.cycle_count !== 32'd50) begin n_fail++; $display("[TB] FAIL wd_count: got %0d expected 50", w_if.cycle_count); end
`else
    n_checks++; if (w_if.state !== RUN) begin n_fail++; $display("[TB] FAIL nowd_state: got %0d expected %0d", w_if.state, RUN); end
    n_checks++; if (w_if.timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL nowd_timeout: got %b expected 0", w_if.timeout); end
    n_checks++; if (w_if.running !== 1'b1) begin n_fail++; $display("[TB] FAIL nowd_running: got %b expected 1", w_if.running); end
`endif
  endtask

  task automatic test_finish_in_hold();
    RST = 1'b1;
    a_if.finish_req = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++; if (a_if.dut_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_req_edge%0d: got %b expected 0", e, a_if.dut_rst_n); end
    end
    a_if.finish_req = 1'b0;
    n_checks++; if (a_if.state !== DRAIN) begin n_fail++; $display("[TB] FAIL hold_req_state: got %0d expected %0d", a_if.state, DRAIN); end
    repeat (3) tick();
    n_checks++; if (a_if.sim_done !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_req_early_done: got %b expected 0", a_if.sim_done); end
    tick();
    n_checks++; if (a_if.state !== DONE) begin n_fail++; $display("[TB] FAIL hold_req_done: got %0d expected %0d", a_if.state, DONE); end
    n_checks++; if (a_if.cycle_count !== 32'd4) begin n_fail++; $display("[TB] FAIL hold_req_count: got %0d expected 4", a_if.cycle_count); end
    n_checks++; if (a_if.dut_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_req_dut_rst_n: got %b expected 0", a_if.dut_rst_n); end
    n_checks++; if (a_if.running !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_req_running: got %b expected 0", a_if.running); end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    repeat (20) tick();
    n_checks++; if (a_if.state !== RUN) begin n_fail++; $display("[TB] FAIL mid_run_state: got %0d expected %0d", a_if.state, RUN); end
    a_if.finish_req = 1'b1;
    tick();
    a_if.finish_req = 1'b0;
    tick();
    n_checks++; if (a_if.state !== DRAIN) begin n_fail++; $display("[TB] FAIL mid_drain_state: got %0d expected %0d", a_if.state, DRAIN); end
    #2 RST = 1'b1;
    #1;
    n_checks++; if (a_if.state !== HOLD) begin n_fail++; $display("[TB] FAIL async_state: got %0d expected %0d", a_if.state, HOLD); end
    n_checks++; if (a_if.cycle_count !== 32'd0) begin n_fail++; $display("[TB] FAIL async_count: got %0d expected 0", a_if.cycle_count); end
    n_checks++; if (a_if.dut_rst_n !== 1'b0) begin n_fail++; $display("[TB] FAIL async_dut_rst_n: got %b expected 0", a_if.dut_rst_n); end
    n_checks++; if (a_if.sim_done !== 1'b0) begin n_fail++; $display("[TB] FAIL async_sim_done: got %b expected 0", a_if.sim_done); end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e >= 19) begin
        n_checks++; if (a_if.dut_rst_n !== (e == 20)) begin n_fail++; $display("[TB] FAIL rerun_edge%0d: got %b expected %b", e, a_if.dut_rst_n, (e == 20)); end
      end
    end
    a_if.finish_req = 1'b1;
    tick();
    a_if.finish_req = 1'b0;
    n_checks++; if (a_if.state !== DRAIN) begin n_fail++; $display("[TB] FAIL rerun_drain: got %0d expected %0d", a_if.state, DRAIN); end
    repeat (3) tick();
    n_checks++; if (a_if.sim_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rerun_early_done: got %b expected 0", a_if.sim_done); end
    tick();
    n_checks++; if (a_if.sim_done !== 1'b1) begin n_fail++; $display("[TB] FAIL rerun_sim_done: got %b expected 1", a_if.sim_done); end
    n_checks++; if (a_if.cycle_count !== 32'd5) begin n_fail++; $display("[TB] FAIL rerun_count: got %0d expected 5", a_if.cycle_count); end
  endtask

  initial begin
    a_if.finish_req = 1'b0;
    z_if.finish_req = 1'b0;
    w_if.finish_req = 1'b0;
    test_reset();
    test_drain_zero();
    test_finish_drain();
    test_watchdog();
    test_finish_in_hold();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
